// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    ISSUE   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } arb_state_e;

  // Upper nibble of the channel tag byte.
  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  // Largest supported requester count (tag carries a 4-bit channel id).
  localparam int unsigned MAX_CH = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first set request above 'last', wrapping.
module rr_priority_pick
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned GW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [GW-1:0]     last,
  output logic [GW-1:0]     gnt_id,
  output logic              any
);

  logic          found;
  logic [GW-1:0] idx;

  // Scan (last+1) .. (last+NUM_CH) mod NUM_CH; the first hit wins.
  always_comb begin
    gnt_id = last;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = GW'((32'(last) + i) % NUM_CH);
      if (!found && req[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx between NUM_CH
// byte-stream requesters.
// Optional feature: define UART_ARB_CHAN_TAG_EN to prefix every packet with
// a tag byte {4'hA, grant_id[3:0]}.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_CH       = 4,
  parameter  int unsigned PAYLOAD_BITS = 8,
  localparam int unsigned GW           = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              req_valid,
  input  logic [NUM_CH*PAYLOAD_BITS-1:0] req_data,
  input  logic [NUM_CH-1:0]              req_last,
  output logic [NUM_CH-1:0]              req_ready,
  output logic                           tx_en,
  output logic [PAYLOAD_BITS-1:0]        tx_data,
  input  logic                           tx_busy,
  output logic [GW-1:0]                  grant_id,
  output logic                           locked
);

  arb_state_e              state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic                    locked_q, locked_d;
  logic                    last_q, last_d;
  logic                    tx_en_q, tx_en_d;
  logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
  logic [NUM_CH-1:0]       ready_q, ready_d;
`ifdef UART_ARB_CHAN_TAG_EN
  logic                    tag_pend_q, tag_pend_d;
`endif

  logic [PAYLOAD_BITS-1:0] data_arr [NUM_CH];
  logic [GW-1:0]           pick_id;
  logic                    pick_any;

  // Split the flat data bus into per-channel bytes.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign data_arr[k] = req_data[k*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  rr_priority_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req    (req_valid),
    .last   (last_grant_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    locked_d     = locked_q;
    last_d       = last_q;
    tx_en_d      = 1'b0;
    tx_data_d    = tx_data_q;
    ready_d      = '0;
`ifdef UART_ARB_CHAN_TAG_EN
    tag_pend_d   = tag_pend_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) state_d = ARB;
      end
      ARB: begin
        if (!locked_q) begin
          if (pick_any) begin
            grant_d   = pick_id;
            locked_d  = 1'b1;
            state_d   = ISSUE;
            tx_en_d   = 1'b1;
`ifdef UART_ARB_CHAN_TAG_EN
            // New grant: the first issue is the tag, nothing is consumed.
            tag_pend_d = 1'b1;
            tx_data_d  = PAYLOAD_BITS'({TAG_NIBBLE, 4'(pick_id)});
`else
            tx_data_d = data_arr[pick_id];
            ready_d   = NUM_CH'(1) << pick_id;
`endif
          end
        end else if (req_valid[grant_q]) begin
          // Mid-packet: only the holder may proceed.
          state_d   = ISSUE;
          tx_en_d   = 1'b1;
          tx_data_d = data_arr[grant_q];
          ready_d   = NUM_CH'(1) << grant_q;
        end
      end
      ISSUE: begin
        state_d = WAIT_HI;
`ifdef UART_ARB_CHAN_TAG_EN
        last_d     = tag_pend_q ? 1'b0 : req_last[grant_q];
        tag_pend_d = 1'b0;
`else
        last_d = req_last[grant_q];
`endif
      end
      WAIT_HI: begin
        if (tx_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            locked_d     = 1'b0;
            last_grant_d = grant_q;
            state_d      = pick_any ? ARB : IDLE;
          end else begin
            state_d = ARB;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_CH - 1);
      locked_q     <= 1'b0;
      last_q       <= 1'b0;
      tx_en_q      <= 1'b0;
      tx_data_q    <= '0;
      ready_q      <= '0;
`ifdef UART_ARB_CHAN_TAG_EN
      tag_pend_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      locked_q     <= locked_d;
      last_q       <= last_d;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
      ready_q      <= ready_d;
`ifdef UART_ARB_CHAN_TAG_EN
      tag_pend_q   <= tag_pend_d;
`endif
    end
  end

  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
  assign req_ready = ready_q;
  assign grant_id  = grant_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-based requester models,
// a uart_tx busy model, and a packet-level scoreboard.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned PB     = 8;
  localparam int unsigned GW     = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_CH-1:0]      req_valid = '0;
  logic [NUM_CH*PB-1:0]   req_data = '0;
  logic [NUM_CH-1:0]      req_last = '0;
  logic [NUM_CH-1:0]      req_ready;
  logic                   tx_en;
  logic [PB-1:0]          tx_data;
  logic                   tx_busy = 1'b0;
  logic [GW-1:0]          grant_id;
  logic                   locked;

  int n_assert = 0;
  int n_fail   = 0;

  // Requester queues: {last, data}; popped one negedge after the handshake.
  logic [8:0]        src_q [NUM_CH][$];
  logic [NUM_CH-1:0] hold = '0;
  logic [NUM_CH-1:0] pend_pop = '0;
  logic [NUM_CH-1:0] valid_prev = '0;
  logic [11:0]       log_q [$];
  logic [11:0]       exp_q [$];
  int  busy_cnt = 0;
  int  cyc = 0;
  int  hs_count = 0;
  int  bytes_sent = 0;
  bit  in_pkt = 0;
  int  cur_ch = 0;
  int  last_ch = NUM_CH - 1;
  bit  lat_arm = 0;
  int  t_valid = -1;
  int  t_txen = -1;

  uart_tx_arbiter #(
    .NUM_CH       (NUM_CH),
    .PAYLOAD_BITS (PB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid channel strictly after 'last', wrapping.
  function automatic int rr_pick(input logic [NUM_CH-1:0] v, input int last);
    for (int i = 1; i <= NUM_CH; i++)
      if (v[(last + i) % NUM_CH]) return (last + i) % NUM_CH;
    return -1;
  endfunction

  function automatic bit queues_empty();
    for (int c = 0; c < NUM_CH; c++)
      if (src_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int ch, input logic [7:0] d, input bit last);
    src_q[ch].push_back({last, d});
  endtask

  // uart_tx model: busy rises the cycle after tx_en, stays up for a random frame.
  always @(posedge clk) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_en) begin
      tx_busy  <= 1'b1;
      busy_cnt <= int'($urandom_range(3, 8));
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  // Scoreboard and requester driver, both away from the active edge.
  always @(negedge clk) begin
    logic [8:0] head;
    int g;
    cyc++;
    if (!rst_n) begin
      pend_pop = '0;
      in_pkt   = 0;
      last_ch  = NUM_CH - 1;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (pend_pop[c]) begin
          if (src_q[c].size() > 0) void'(src_q[c].pop_front());
          pend_pop[c] = 1'b0;
        end
      if (tx_en) begin
        g = int'(grant_id);
        if (lat_arm && t_txen < 0) t_txen = cyc;
        check("tx_en_while_busy", tx_busy, 0);
        check("locked_at_issue", locked, 1);
        if (!in_pkt) check("rr_grant", grant_id, rr_pick(valid_prev, last_ch));
        else         check("no_interleave", grant_id, cur_ch);
        cur_ch = g;
`ifdef UART_ARB_CHAN_TAG_EN
        if (!in_pkt) begin
          check("tag_data", tx_data, {4'hA, 4'(g)});
          check("tag_ready", req_ready, 0);
          in_pkt = 1;
        end else
`endif
        begin
          check("ready_onehot", req_ready, 1 << g);
          check("valid_at_issue", req_valid[g], 1);
          check("src_has_byte", src_q[g].size() > 0, 1);
          if (src_q[g].size() > 0) begin
            head = src_q[g][0];
            check("tx_data", tx_data, head[7:0]);
            log_q.push_back({4'(g), tx_data});
            pend_pop[g] = 1'b1;
            hs_count++;
            bytes_sent++;
            in_pkt = !head[8];
            if (head[8]) last_ch = g;
          end
        end
      end else begin
        check("ready_without_tx_en", req_ready, 0);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!hold[c] && src_q[c].size() > 0) begin
        head = src_q[c][0];
        req_valid[c]         = 1'b1;
        req_data[c*PB +: PB] = head[7:0];
        req_last[c]          = head[8];
      end else begin
        req_valid[c]         = 1'b0;
        req_data[c*PB +: PB] = '0;
        req_last[c]          = 1'b0;
      end
    end
    if (lat_arm && t_valid < 0 && req_valid != '0) t_valid = cyc;
    valid_prev = req_valid;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget && !(queues_empty() && pend_pop == '0 && locked === 1'b0 &&
                           tx_busy === 1'b0 && tx_en === 1'b0)) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < budget, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("handshake_timeout", n < budget, 1);
  endtask

  task automatic check_log();
    check("log_len", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size()) check("log_entry", log_q[i], exp_q[i]);
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    repeat (2) @(negedge clk);
    log_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int pushed;
    int base;
    int npk;
    int len;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_locked", locked, 0);
    rst_n = 1'b1;

    // Single channel, 3-byte packet, with arbitration latency
    @(posedge clk); #1;
    lat_arm = 1;
    push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1);
    wait_idle(2000);
    check("arb_latency", t_txen - t_valid, 2);
    lat_arm = 0;
    check("single_locked_clear", locked, 0);
    check("single_grant_kept", grant_id, 1);
    exp_q = '{12'h111, 12'h122, 12'h133};
    check_log();

    // Contention after reset: ch0 fully, then ch2
    do_reset();
    @(posedge clk); #1;
    push(0, 8'hA0, 0); push(0, 8'hA1, 1);
    push(2, 8'hC0, 0); push(2, 8'hC1, 1);
    wait_idle(2000);
    exp_q = '{12'h0A0, 12'h0A1, 12'h2C0, 12'h2C1};
    check_log();

    // Fairness: ch0 and ch3 streaming 1-byte packets alternate
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      push(0, 8'(i), 1);
      push(3, 8'(8'h30 + i), 1);
    end
    wait_idle(4000);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({4'd0, 8'(i)});
      exp_q.push_back({4'd3, 8'(8'h30 + i)});
    end
    check_log();

    // Mid-packet stall: ch2 holds the grant while ch0 waits
    @(posedge clk); #1;
    push(2, 8'h21, 0); push(2, 8'h22, 0); push(2, 8'h23, 1);
    wait_hs(hs_count + 1, 500);
    @(posedge clk); #1;
    hold[2] = 1'b1;
    push(0, 8'h0A, 1);
    repeat (50) @(negedge clk);
    check("stall_grant", grant_id, 2);
    check("stall_locked", locked, 1);
    check("stall_bytes", log_q.size(), 1);
    hold[2] = 1'b0;
    wait_idle(2000);
    exp_q = '{12'h221, 12'h222, 12'h223, 12'h00A};
    check_log();

    // Reset during WAIT_LO abandons the packet
    @(posedge clk); #1;
    push(1, 8'h71, 0); push(1, 8'h72, 0); push(1, 8'h73, 1);
    n = 0;
    while (tx_busy !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", n < 500, 1);
    @(negedge clk);
    check("pre_rst_locked", locked, 1);
    rst_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    @(negedge clk);
    check("midrst_tx_en", tx_en, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_locked", locked, 0);
    check("midrst_grant_id", grant_id, 0);
    log_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized packets on all channels
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      pushed = 0;
      base   = bytes_sent;
      for (int c = 0; c < NUM_CH; c++) begin
        npk = int'($urandom_range(0, 2));
        for (int p = 0; p < npk; p++) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++) begin
            push(c, 8'($urandom), b == len - 1);
            pushed++;
          end
        end
      end
      wait_idle(20000);
      check("rand_byte_count", bytes_sent - base, pushed);
      log_q.delete();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
